mem_access_unit: RTL and testbench

Load/store unit sitting directly downstream of the control decoder in the single-issue RV32 core. It consumes the decoder's `readMemEnable`, `writeMemEnable` and `memOP` (funct3) together with the ALU-computed address and rs2 store data. It runs one AXI4-Lite-style transaction per instruction, then returns sign/zero-extended load data (or store completion) to write-back through a valid/ready handshake. One request is in flight at a time; there is no buffering beyond the single captured request.

---
 rtl/mem_access_unit_if.sv | 32 +++
 rtl/mem_access_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// AXI4-Lite style memory bus between the load/store unit (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: one bus transaction per request, extended
// load data or store completion returned through a valid/ready handshake.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rd_en,
    input  logic              in_wr_en,
    input  logic [2:0]        in_mem_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_err,
    mem_access_unit_if.master bus
);

    typedef enum logic [2:0] {IDLE, AR, R, W, B, RESP} state_t;

    state_t            state, state_n;
    logic [1:0]        off_q, off_n;
    logic [2:0]        op_q, op_n;
    logic              arvalid_q, arvalid_n;
    logic [ADDR_W-1:0] araddr_q, araddr_n;
    logic              rready_q, rready_n;
    logic              awvalid_q, awvalid_n;
    logic [ADDR_W-1:0] awaddr_q, awaddr_n;
    logic              wvalid_q, wvalid_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [3:0]        wstrb_q, wstrb_n;
    logic              bready_q, bready_n;
    logic              out_valid_q, out_valid_n;
    logic [31:0]       out_rdata_q, out_rdata_n;
    logic              out_err_q, out_err_n;

    logic              load_legal, store_legal, aligned;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       store_data, rshift, load_data;
    logic [3:0]        store_strb;

    // Request decode works on the inputs at accept so bus traffic starts the next cycle.
    always_comb begin
        load_legal  = in_mem_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_legal = in_mem_op inside {3'b000, 3'b001, 3'b010};
        case (in_mem_op[1:0])
            2'b01:   aligned = !in_addr[0];
            2'b10:   aligned = (in_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        word_addr = {in_addr[ADDR_W-1:2], 2'b00};
        case (in_mem_op[1:0])
            2'b00: begin
                store_data = {4{in_wdata[7:0]}};
                store_strb = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                store_data = {2{in_wdata[15:0]}};
                store_strb = 4'b0011 << in_addr[1:0];
            end
            default: begin
                store_data = in_wdata;
                store_strb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rshift = bus.rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
            3'b010:  load_data = bus.rdata;
            3'b100:  load_data = {24'h0, rshift[7:0]};
            3'b101:  load_data = {16'h0, rshift[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_n     = state;
        off_n       = off_q;
        op_n        = op_q;
        arvalid_n   = arvalid_q;
        araddr_n    = araddr_q;
        rready_n    = rready_q;
        awvalid_n   = awvalid_q;
        awaddr_n    = awaddr_q;
        wvalid_n    = wvalid_q;
        wdata_n     = wdata_q;
        wstrb_n     = wstrb_q;
        bready_n    = bready_q;
        out_valid_n = out_valid_q;
        out_rdata_n = out_rdata_q;
        out_err_n   = out_err_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    off_n = in_addr[1:0];
                    op_n  = in_mem_op;
                    if (!in_rd_en && !in_wr_en) begin
                        state_n     = RESP;
                        out_valid_n = 1'b1;
                        out_err_n   = 1'b0;
                        out_rdata_n = '0;
                    end else if (in_rd_en && !in_wr_en && load_legal && aligned) begin
                        state_n   = AR;
                        arvalid_n = 1'b1;
                        araddr_n  = word_addr;
                    end else if (in_wr_en && !in_rd_en && store_legal && aligned) begin
                        state_n   = W;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        awaddr_n  = word_addr;
                        wdata_n   = store_data;
                        wstrb_n   = store_strb;
                    end else begin
                        state_n     = RESP;
                        out_valid_n = 1'b1;
                        out_err_n   = 1'b1;
                        out_rdata_n = '0;
                    end
                end
            end
            AR: begin
                if (bus.arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = R;
                end
            end
            R: begin
                if (bus.rvalid) begin
                    rready_n    = 1'b0;
                    out_valid_n = 1'b1;
                    out_err_n   = (bus.rresp != 2'b00);
                    out_rdata_n = (bus.rresp != 2'b00) ? '0 : load_data;
                    state_n     = RESP;
                end
            end
            W: begin
                // Address and data channels retire independently; leave once both are done.
                if (bus.awready) awvalid_n = 1'b0;
                if (bus.wready)  wvalid_n  = 1'b0;
                if ((!awvalid_q || bus.awready) && (!wvalid_q || bus.wready)) begin
                    bready_n = 1'b1;
                    state_n  = B;
                end
            end
            B: begin
                if (bus.bvalid) begin
                    bready_n    = 1'b0;
                    out_valid_n = 1'b1;
                    out_err_n   = (bus.bresp != 2'b00);
                    out_rdata_n = '0;
                    state_n     = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            off_q       <= '0;
            op_q        <= '0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bready_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state       <= state_n;
            off_q       <= off_n;
            op_q        <= op_n;
            arvalid_q   <= arvalid_n;
            araddr_q    <= araddr_n;
            rready_q    <= rready_n;
            awvalid_q   <= awvalid_n;
            awaddr_q    <= awaddr_n;
            wvalid_q    <= wvalid_n;
            wdata_q     <= wdata_n;
            wstrb_q     <= wstrb_n;
            bready_q    <= bready_n;
            out_valid_q <= out_valid_n;
            out_rdata_q <= out_rdata_n;
            out_err_q   <= out_err_n;
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = out_valid_q;
    assign out_rdata   = out_rdata_q;
    assign out_err     = out_err_q;
    assign bus.arvalid = arvalid_q;
    assign bus.araddr  = araddr_q;
    assign bus.rready  = rready_q;
    assign bus.awvalid = awvalid_q;
    assign bus.awaddr  = awaddr_q;
    assign bus.wvalid  = wvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.bready  = bready_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of single transactions on a
// zero-wait bus, plus hand sequences for stalls, error hold and mid-flight reset.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_rd_en = 1'b0;
    logic        in_wr_en = 1'b0;
    logic [2:0]  in_mem_op = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;

    int n_vec = 0;
    int n_bad = 0;

    mem_access_unit_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd_en  (in_rd_en),
        .in_wr_en  (in_wr_en),
        .in_mem_op (in_mem_op),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_err   (out_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] bdata;
        logic [1:0]  resp;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_bus;   // 0 none, 1 read, 2 write
        logic [31:0] e_baddr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic wr, logic [2:0] op, logic [31:0] addr,
                                logic [31:0] wd, logic [31:0] bdata, logic [1:0] resp,
                                logic [31:0] e_rdata, logic e_err, int e_lat, int e_bus,
                                logic [31:0] e_baddr, logic [3:0] e_strb, logic [31:0] e_wdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.op = op; v.addr = addr; v.wd = wd; v.bdata = bdata;
        v.resp = resp; v.e_rdata = e_rdata; v.e_err = e_err; v.e_lat = e_lat;
        v.e_bus = e_bus; v.e_baddr = e_baddr; v.e_strb = e_strb; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        in_valid = 1'b1; in_rd_en = rd; in_wr_en = wr;
        in_mem_op = op; in_addr = addr; in_wdata = wd;
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; in_rd_en = 1'b0; in_wr_en = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        chk(name, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_hs", {31'b0, out_valid}, 32'd0);
        chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
        bus.rvalid = 1'b0;  bus.bvalid = 1'b0;
        bus.rdata = '0; bus.rresp = '0; bus.bresp = '0;

        //        rd wr op      addr          wd            bdata         resp   e_rdata       err lat bus baddr         strb     wdata
        vecs.push_back(mk(1, 0, 3'b000, 32'h8000_0003, 32'h0,         32'h80FF_1234, 2'b00, 32'hFFFF_FF80, 0, 3, 1, 32'h8000_0000, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b101, 32'h8000_0002, 32'h0,         32'hBEEF_0000, 2'b00, 32'h0000_BEEF, 0, 3, 1, 32'h8000_0000, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b001, 32'h8000_0002, 32'h0,         32'hBEEF_0000, 2'b00, 32'hFFFF_BEEF, 0, 3, 1, 32'h8000_0000, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b010, 32'h8000_0001, 32'h0,         32'h1111_1111, 2'b00, 32'h0,         1, 1, 0, 32'h0,         4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b011, 32'h8000_0000, 32'h0,         32'h1111_1111, 2'b00, 32'h0,         1, 1, 0, 32'h0,         4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b100, 32'h1000_0001, 32'h0,         32'h1234_5678, 2'b00, 32'h0000_0056, 0, 3, 1, 32'h1000_0000, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b010, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 0, 3, 1, 32'h1000_0004, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b010, 32'h1000_0008, 32'h0,         32'hDEAD_BEEF, 2'b10, 32'h0,         1, 3, 1, 32'h1000_0008, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h1000_0000, 32'h0,         32'h1234_567F, 2'b00, 32'h0000_007F, 0, 3, 1, 32'h1000_0000, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b101, 32'h3000_0000, 32'h0,         32'hBEEF_8234, 2'b00, 32'h0000_8234, 0, 3, 1, 32'h3000_0000, 4'h0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b001, 32'h3000_0000, 32'h0,         32'hBEEF_8234, 2'b00, 32'hFFFF_8234, 0, 3, 1, 32'h3000_0000, 4'h0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h2000_0001, 32'h0000_00AB, 32'h0,         2'b00, 32'h0,         0, 3, 2, 32'h2000_0000, 4'b0010, 32'hABAB_ABAB));
        vecs.push_back(mk(0, 1, 3'b010, 32'h2000_0008, 32'hCAFE_F00D, 32'h0,         2'b00, 32'h0,         0, 3, 2, 32'h2000_0008, 4'b1111, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 1, 3'b001, 32'h2000_0006, 32'h9999_ABCD, 32'h0,         2'b00, 32'h0,         0, 3, 2, 32'h2000_0004, 4'b1100, 32'hABCD_ABCD));
        vecs.push_back(mk(0, 0, 3'b010, 32'h2000_0000, 32'h1234_5678, 32'h5555_5555, 2'b00, 32'h0,         0, 1, 0, 32'h0,         4'h0, 32'h0));
        vecs.push_back(mk(1, 1, 3'b010, 32'h2000_0000, 32'h1234_5678, 32'h5555_5555, 2'b00, 32'h0,         1, 1, 0, 32'h0,         4'h0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b001, 32'h2000_0001, 32'h1234_5678, 32'h0,         2'b00, 32'h0,         1, 1, 0, 32'h0,         4'h0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b100, 32'h2000_0000, 32'h1234_5678, 32'h0,         2'b00, 32'h0,         1, 1, 0, 32'h0,         4'h0, 32'h0));

        // reset state
        repeat (2) tick();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_valids", {24'b0, out_valid, out_err, bus.arvalid, bus.rready,
                           bus.awvalid, bus.wvalid, bus.bready, 1'b0}, 32'd0);
        chk("rst_out_rdata", out_rdata, 32'd0);
        chk("rst_araddr", bus.araddr, 32'd0);
        chk("rst_wstrb", {28'b0, bus.wstrb}, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            vec_t v;
            int lat;
            logic saw_ar, saw_aw;
            logic [31:0] ar_a, aw_a, w_d;
            logic [3:0] w_s;
            v = vecs[i];
            saw_ar = 1'b0; saw_aw = 1'b0; ar_a = '0; aw_a = '0; w_d = '0; w_s = '0;
            bus.rdata = v.bdata; bus.rresp = v.resp; bus.bresp = v.resp;
            bus.rvalid = 1'b1; bus.bvalid = 1'b1;
            issue(v.rd, v.wr, v.op, v.addr, v.wd);
            lat = 1;
            while (!out_valid && lat < 20) begin
                if (bus.arvalid) begin saw_ar = 1'b1; ar_a = bus.araddr; end
                if (bus.awvalid) begin saw_aw = 1'b1; aw_a = bus.awaddr; w_d = bus.wdata; w_s = bus.wstrb; end
                tick();
                lat++;
            end
            chk($sformatf("v%0d_latency", i), lat, v.e_lat);
            chk($sformatf("v%0d_rdata", i), out_rdata, v.e_rdata);
            chk($sformatf("v%0d_err", i), {31'b0, out_err}, {31'b0, v.e_err});
            chk($sformatf("v%0d_ar_seen", i), {31'b0, saw_ar}, {31'b0, v.e_bus == 1});
            chk($sformatf("v%0d_aw_seen", i), {31'b0, saw_aw}, {31'b0, v.e_bus == 2});
            if (v.e_bus == 1) chk($sformatf("v%0d_araddr", i), ar_a, v.e_baddr);
            if (v.e_bus == 2) begin
                chk($sformatf("v%0d_awaddr", i), aw_a, v.e_baddr);
                chk($sformatf("v%0d_wstrb", i), {28'b0, w_s}, {28'b0, v.e_strb});
                chk($sformatf("v%0d_wdata", i), w_d, v.e_wdata);
            end
            handshake();
            bus.rvalid = 1'b0; bus.bvalid = 1'b0;
        end

        // sh with awready two cycles after wready
        bus.awready = 1'b0; bus.wready = 1'b1; bus.bresp = 2'b00;
        issue(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678);
        chk("sh_both_valid", {30'b0, bus.awvalid, bus.wvalid}, 32'd3);
        chk("sh_wstrb", {28'b0, bus.wstrb}, 32'h0000_000C);
        chk("sh_wdata", bus.wdata, 32'h5678_5678);
        tick();
        chk("sh_aw_held_w_done_1", {30'b0, bus.awvalid, bus.wvalid}, 32'd2);
        tick();
        chk("sh_aw_held_w_done_2", {30'b0, bus.awvalid, bus.wvalid}, 32'd2);
        chk("sh_awaddr_stable", bus.awaddr, 32'h8000_0000);
        bus.awready = 1'b1;
        tick();
        chk("sh_aw_dropped", {31'b0, bus.awvalid}, 32'd0);
        chk("sh_bready", {31'b0, bus.bready}, 32'd1);
        chk("sh_no_early_out", {31'b0, out_valid}, 32'd0);
        bus.bvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        chk("sh_out_valid", {31'b0, out_valid}, 32'd1);
        chk("sh_err", {31'b0, out_err}, 32'd0);
        handshake();
        tick();
        chk("sh_single_out_valid", {31'b0, out_valid}, 32'd0);

        // sw with SLVERR, write-back stalls for 4 cycles
        bus.bresp = 2'b10; bus.bvalid = 1'b1;
        issue(1'b0, 1'b1, 3'b010, 32'h2000_0010, 32'hA5A5_5A5A);
        wait_out("sw_err_out_valid");
        bus.bvalid = 1'b0; bus.bresp = 2'b00;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("stall%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stall%0d_err", c), {31'b0, out_err}, 32'd1);
            chk($sformatf("stall%0d_rdata", c), out_rdata, 32'd0);
            chk($sformatf("stall%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
            tick();
        end
        handshake();

        // reset while waiting in R, then a stray rvalid
        bus.rvalid = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h4000_0004, 32'h0);
        chk("r_arvalid", {31'b0, bus.arvalid}, 32'd1);
        tick();
        chk("r_rready", {31'b0, bus.rready}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_valids", {24'b0, out_valid, out_err, bus.arvalid, bus.rready,
                              bus.awvalid, bus.wvalid, bus.bready, 1'b0}, 32'd0);
        chk("midrst_araddr", bus.araddr, 32'd0);
        chk("midrst_awaddr", bus.awaddr, 32'd0);
        chk("midrst_wdata", bus.wdata, 32'd0);
        bus.rvalid = 1'b1; bus.rdata = 32'hFFFF_FFFF;
        chk("stray_rready", {31'b0, bus.rready}, 32'd0);
        tick();
        chk("stray_out_valid", {31'b0, out_valid}, 32'd0);
        chk("stray_in_ready", {31'b0, in_ready}, 32'd1);
        bus.rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
